// File: rtl/whack_round_ctrl.sv
// Round controller for a five-mole whack game: asks the RNG for a target, lights the mole,
// judges the player's press or timeout, and tracks score and misses until the game ends.
module whack_round_ctrl #(
  parameter int ON_TICKS   = 25000000,
  parameter int GAP_TICKS  = 5000000,
  parameter int MAX_MISSES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] target,
  input  logic [4:0] buttons,
  output logic       generateEn,
  output logic [4:0] mole,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over,
  output logic       busy
);

  localparam int TICK_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW       = $clog2(TICK_MAX + 1);

  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(1);
  localparam logic [TW-1:0] TICK_ONE   = TW'(1);
  localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISSES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_TGT,
    SHOW,
    GAP,
    OVER
  } state_t;

  state_t        state;
  logic          start_q;
  logic [4:0]    buttons_prev;
  logic [4:0]    press;
  logic [4:0]    safe_target;
  logic          target_onehot;
  logic          round_hit;
  logic          round_miss;
  logic [TW-1:0] on_timer;
  logic [TW-1:0] gap_timer;

  assign press         = buttons & ~buttons_prev;
  assign target_onehot = (target != 5'd0) && ((target & (target - 5'd1)) == 5'd0);
  assign safe_target   = target_onehot ? target : 5'b00001;

  // A press always decides the round, even on the cycle the mole would otherwise time out.
  assign round_hit  = (state == SHOW) && (press != 5'd0) && (press == mole);
  assign round_miss = (state == SHOW) &&
                      (((press != 5'd0) && (press != mole)) ||
                       ((press == 5'd0) && (on_timer == ON_LAST)));

  // start is registered once before the FSM looks at it, which puts the mole four edges
  // after the edge that first samples start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      buttons_prev <= 5'b11111;
      on_timer     <= '0;
      gap_timer    <= '0;
      mole         <= 5'd0;
      score        <= 8'd0;
      misses       <= 4'd0;
      generateEn   <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      game_over    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      start_q      <= start;
      buttons_prev <= buttons;
      generateEn   <= 1'b0;
      hit_pulse    <= round_hit;
      miss_pulse   <= round_miss;

      if (round_hit && (score != 8'hFF)) begin
        score <= score + 8'd1;
      end
      if (round_miss && (misses != 4'hF)) begin
        misses <= misses + 4'd1;
      end

      case (state)
        IDLE: begin
          if (start_q) begin
            state      <= REQ;
            generateEn <= 1'b1;
            busy       <= 1'b1;
          end
        end

        REQ: begin
          state     <= WAIT_TGT;
          gap_timer <= '0;
        end

        WAIT_TGT: begin
          if (gap_timer == WAIT_LAST) begin
            mole      <= safe_target;
            state     <= SHOW;
            on_timer  <= '0;
            gap_timer <= '0;
          end else begin
            gap_timer <= gap_timer + TICK_ONE;
          end
        end

        SHOW: begin
          if (round_hit || round_miss) begin
            mole      <= 5'd0;
            state     <= GAP;
            on_timer  <= '0;
            gap_timer <= '0;
          end else begin
            on_timer <= on_timer + TICK_ONE;
          end
        end

        GAP: begin
          if (gap_timer == GAP_LAST) begin
            gap_timer <= '0;
            if (misses >= MISS_LIMIT) begin
              state     <= OVER;
              game_over <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state      <= REQ;
              generateEn <= 1'b1;
            end
          end else begin
            gap_timer <= gap_timer + TICK_ONE;
          end
        end

        OVER: begin
          if (start_q) begin
            score      <= 8'd0;
            misses     <= 4'd0;
            game_over  <= 1'b0;
            busy       <= 1'b1;
            generateEn <= 1'b1;
            state      <= REQ;
          end
        end

        default: begin
          state <= IDLE;
          mole  <= 5'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/whack_round_ctrl.md
WHACK_ROUND_CTRL -- requirements
Module: whack_round_ctrl

Interface
REQ-001 Parameter ON_TICKS, default 25000000: clock cycles a mole stays lit before counting as a miss.
REQ-002 Parameter GAP_TICKS, default 5000000: dark cycles between rounds.
REQ-003 Parameter MAX_MISSES, default 3: miss count that ends the game, range 1..15.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level, sampled each cycle; begins or restarts a game.
REQ-007 target  in  5  one-hot mole choice from the RNG stage, read only when the block samples it.
REQ-008 buttons  in  5  debounced player buttons, active-high level, bit i whacks mole i.
REQ-009 generateEn  out  1  request to the RNG stage for a new target.
REQ-010 mole  out  5  currently lit mole, one-hot or zero.
REQ-011 score  out  8  hit count.
REQ-012 misses  out  4  miss count.
REQ-013 hit_pulse, miss_pulse  out  1 each  single-cycle round-outcome strobes.
REQ-014 game_over  out  1  high while in OVER.
REQ-015 busy  out  1  high in every state except IDLE and OVER.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT_TGT, SHOW, GAP and OVER; all outputs SHALL be registered.
REQ-017 IDLE: the block SHALL go to REQ on the first cycle start=1; otherwise it SHALL stay in IDLE.
REQ-018 REQ: generateEn SHALL be 1 for exactly this one cycle (0 in every other state), then the FSM SHALL move to WAIT_TGT.
REQ-019 WAIT_TGT: the FSM SHALL stay exactly 2 cycles, then latch target and enter SHOW.
REQ-020 If the latched target is not exactly one-hot (zero, or more than one bit set), the block SHALL substitute 5'b00001.
REQ-021 Latency: with start sampled at edge E, generateEn SHALL be high from E+1 to E+2, target SHALL be latched at E+4, and mole SHALL be valid from E+4.
REQ-022 SHOW: mole SHALL equal the latched target, and a timer SHALL count from 0.
REQ-023 Button edges: press = buttons & ~buttons_prev, with buttons_prev registered every cycle.
REQ-024 In SHOW, press == mole SHALL be a hit: score+1 (saturating at 255), hit_pulse=1 for one cycle, go to GAP.
REQ-025 In SHOW, a nonzero press != mole (wrong button, or several buttons at once) SHALL be a miss.
REQ-026 In SHOW, reaching ON_TICKS cycles with no press SHALL be a miss.
REQ-027 A miss SHALL increment misses by 1 (saturating at 15), set miss_pulse=1 for one cycle, and go to GAP.
REQ-028 If a press and the timeout occur in the same cycle, the press SHALL win.
REQ-029 GAP: mole=0, button presses SHALL be ignored, and the state SHALL last exactly GAP_TICKS cycles.
REQ-030 At the end of GAP, the FSM SHALL go to OVER if misses >= MAX_MISSES; otherwise it SHALL go to REQ.
REQ-031 OVER: game_over=1, mole=0, and score and misses SHALL be held.
REQ-032 In OVER, start=1 SHALL clear score and misses to 0 and go to REQ in the same transition.
REQ-033 start SHALL be ignored in REQ, WAIT_TGT, SHOW and GAP.
REQ-034 The timers SHALL be wide enough for max(ON_TICKS, GAP_TICKS) and SHALL clear on every state entry.

Reset
REQ-035 On reset=1 the block SHALL set the state to IDLE, and mole, score, misses, generateEn, hit_pulse, miss_pulse, game_over, busy and both timers to 0.
REQ-036 On reset=1 the block SHALL set buttons_prev to 5'b11111, so that a button held through reset is not a press.
REQ-037 Reset asserted mid-round (any state) SHALL take effect at the next edge and discard the round with no pulse.
REQ-038 The block SHALL not depend on the reset value of target; REQ-020 covers an unknown or zero target.

Verification (ON_TICKS=8, GAP_TICKS=4, MAX_MISSES=2)
REQ-039 Reset, then start high for one cycle, target=5'b00100 -> generateEn is a 1-cycle pulse, mole=00100 four edges after start, busy=1.
REQ-040 During SHOW with mole=00100, buttons rise 00100 -> hit_pulse for one cycle, score=1, mole=0 for 4 cycles, then a new generateEn pulse.
REQ-041 With mole=01000, press 00001 -> miss_pulse, misses=1; with the next mole, no press for 8 cycles -> misses=2, then game_over=1 after GAP.
REQ-042 target=5'b00000 or 5'b00110 at sampling -> mole=00001.
REQ-043 Correct press on the exact timeout cycle -> hit only, with no miss_pulse.
REQ-044 Button held through reset, released and pressed again in SHOW -> no press is detected until the re-press; reset during SHOW -> IDLE and all outputs 0.
